// File: rtl/hilo_mdu_ctrl.sv
// HI/LO register pair and multi-cycle multiply/divide sequencer for EX.
// MULT/MULTU/DIV/DIVU hold the pipeline while they compute. The result is
// parked in a pending register and committed to HI/LO in the DONE cycle,
// which is the cycle the instruction leaves EX. MTHI/MTLO write directly.
//
// Handshake: there is no valid/ready pair on this block. The upstream
// "valid" is ex_valid_i and the back-pressure is stall_o. An instruction
// is accepted in IDLE when ex_valid_i & !flush_i. It stays in EX, and
// keeps its operands stable, for every cycle that stall_o is high. It
// leaves EX on the first clock edge where stall_o is low. flush_i always
// wins and kills the instruction in EX.
module hilo_mdu_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        ex_valid_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic [63:0] hilo_rdata_o
);

    localparam logic [7:0] MULT_OP  = 8'h18;
    localparam logic [7:0] MULTU_OP = 8'h19;
    localparam logic [7:0] DIV_OP   = 8'h1A;
    localparam logic [7:0] DIVU_OP  = 8'h1B;
    localparam logic [7:0] MTHI_OP  = 8'h11;
    localparam logic [7:0] MTLO_OP  = 8'h13;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] DIV_LAST = 5'd31;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] pend;
    logic        pend_nowrite;

    // Multiplier operands and signedness, held for the whole MUL phase.
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_signed;

    // Divider working registers: div_q shifts the dividend out while the
    // quotient bits shift in; div_r is the partial remainder.
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] div_d;
    logic        neg_q;
    logic        neg_r;

    logic        issue_ok;
    logic        is_muldiv;
    logic        is_div;
    logic        is_signed;
    logic        start;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [63:0] ext_a;
    logic [63:0] ext_b;
    logic [63:0] product;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        take;
    logic [31:0] next_r;
    logic [31:0] next_q;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    // Decode, start condition and operand magnitudes.
    always_comb begin
        issue_ok  = ex_valid_i & ~flush_i & (state == S_IDLE);
        is_div    = (aluop_i == DIV_OP) | (aluop_i == DIVU_OP);
        is_muldiv = is_div | (aluop_i == MULT_OP) | (aluop_i == MULTU_OP);
        is_signed = (aluop_i == MULT_OP) | (aluop_i == DIV_OP);
        start     = issue_ok & is_muldiv;
        mag1      = (is_signed & opdata1_i[31]) ? -opdata1_i : opdata1_i;
        mag2      = (is_signed & opdata2_i[31]) ? -opdata2_i : opdata2_i;
    end

    // 64-bit product; sign-extending to 64 bits makes one multiplier serve both signednesses.
    always_comb begin
        ext_a   = {{32{mul_signed & mul_a[31]}}, mul_a};
        ext_b   = {{32{mul_signed & mul_b[31]}}, mul_b};
        product = ext_a * ext_b;
    end

    // One restoring divide step plus the final sign correction.
    always_comb begin
        shifted = {div_r, div_q[31]};
        diff    = shifted - {1'b0, div_d};
        take    = ~diff[32];
        next_r  = take ? diff[31:0] : shifted[31:0];
        next_q  = {div_q[30:0], take};
        q_fix   = neg_q ? -next_q : next_q;
        r_fix   = neg_r ? -next_r : next_r;
    end

    // Flush in MUL/DIV drops stall so the killed instruction leaves EX at once.
    always_comb begin
        stall_o      = resetn & (start | (((state == S_MUL) | (state == S_DIV)) & ~flush_i));
        busy_o       = (state == S_MUL) | (state == S_DIV);
        hilo_rdata_o = {hi, lo};
    end

    // Sequencer FSM and the multiply/divide datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            cnt          <= 5'd0;
            pend         <= 64'd0;
            pend_nowrite <= 1'b0;
            mul_a        <= 32'd0;
            mul_b        <= 32'd0;
            mul_signed   <= 1'b0;
            div_q        <= 32'd0;
            div_r        <= 32'd0;
            div_d        <= 32'd0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt          <= 5'd0;
                        pend_nowrite <= 1'b0;
                        if (is_div) begin
                            div_q <= mag1;
                            div_r <= 32'd0;
                            div_d <= mag2;
                            neg_q <= is_signed & (opdata1_i[31] ^ opdata2_i[31]);
                            neg_r <= is_signed & opdata1_i[31];
                            if (opdata2_i == 32'd0) begin
                                pend_nowrite <= 1'b1;
                                state        <= S_DONE;
                            end else begin
                                state <= S_DIV;
                            end
                        end else begin
                            mul_a      <= opdata1_i;
                            mul_b      <= opdata2_i;
                            mul_signed <= is_signed;
                            state      <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                        if (cnt == MUL_LAST) begin
                            pend  <= product;
                            state <= S_DONE;
                        end
                    end
                end
                S_DIV: begin
                    if (flush_i) begin
                        state <= S_IDLE;
                    end else begin
                        div_r <= next_r;
                        div_q <= next_q;
                        cnt   <= cnt + 5'd1;
                        if (cnt == DIV_LAST) begin
                            pend  <= {r_fix, q_fix};
                            state <= S_DONE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Architectural HI/LO: commit from pending in DONE, or direct MTHI/MTLO in IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if ((state == S_DONE) && !flush_i && !pend_nowrite) begin
            hi <= pend[63:32];
            lo <= pend[31:0];
        end else if (issue_ok && (aluop_i == MTHI_OP)) begin
            hi <= opdata1_i;
        end else if (issue_ok && (aluop_i == MTLO_OP)) begin
            lo <= opdata1_i;
        end
    end

endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Bench for hilo_mdu_ctrl: directed vector table, hand sequences for
// flush/reset corners, then random operations against an arithmetic model.
module tb_hilo_mdu_ctrl;

  localparam int MUL_CYCLES = 2;

  localparam logic [7:0] MULT_OP  = 8'h18;
  localparam logic [7:0] MULTU_OP = 8'h19;
  localparam logic [7:0] DIV_OP   = 8'h1A;
  localparam logic [7:0] DIVU_OP  = 8'h1B;
  localparam logic [7:0] MTHI_OP  = 8'h11;
  localparam logic [7:0] MTLO_OP  = 8'h13;

  logic        clk;
  logic        resetn;
  logic [7:0]  aluop;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        ex_valid;
  logic        flush;
  logic        stall;
  logic        busy;
  logic [63:0] hilo;

  int passed = 0;
  int total  = 0;
  logic [63:0] exp_hilo;

  hilo_mdu_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .aluop_i      (aluop),
    .opdata1_i    (opdata1),
    .opdata2_i    (opdata2),
    .ex_valid_i   (ex_valid),
    .flush_i      (flush),
    .stall_o      (stall),
    .busy_o       (busy),
    .hilo_rdata_o (hilo)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          stall_n;
    logic [63:0] hilo;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Present one instruction in EX and hold it while stall is high.
  // Returns stall cycles and the number of those cycles busy was seen.
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int stalls, output int busys);
    ex_valid = 1'b1;
    aluop    = op;
    opdata1  = a;
    opdata2  = b;
    stalls   = 0;
    busys    = 0;
    while (1) begin
      @(negedge clk);
      if (busy) busys++;
      if (!stall) break;
      stalls++;
      if (stalls > 100) begin
        check("stall_timeout", 64'(stalls), 64'd0);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    aluop    = 8'h00;
  endtask

  function automatic int exp_stall(input logic [7:0] op, input logic [31:0] b);
    if (op == MULT_OP || op == MULTU_OP) return 1 + MUL_CYCLES;
    if (op == DIV_OP || op == DIVU_OP) return (b == 32'd0) ? 1 : 33;
    return 0;
  endfunction

  // Reference model: plain signed/unsigned arithmetic on 64-bit integers.
  function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    int     sa;
    int     sb;
    longint la;
    longint lb;
    longint q;
    longint r;
    logic [63:0] res;
    sa  = a;
    sb  = b;
    res = cur;
    case (op)
      MULT_OP: begin
        la  = sa;
        lb  = sb;
        res = la * lb;
      end
      MULTU_OP: res = {32'd0, a} * {32'd0, b};
      DIV_OP, DIVU_OP: begin
        if (b != 32'd0) begin
          la = (op == DIV_OP) ? longint'(sa) : longint'({32'd0, a});
          lb = (op == DIV_OP) ? longint'(sb) : longint'({32'd0, b});
          q  = la / lb;
          r  = la % lb;
          res = {r[31:0], q[31:0]};
        end
      end
      MTHI_OP: res[63:32] = a;
      MTLO_OP: res[31:0]  = a;
      default: res = cur;
    endcase
    return res;
  endfunction

  initial begin
    int st;
    int bs;
    logic [7:0] ops[6];
    logic [7:0] op;
    logic [31:0] a;
    logic [31:0] b;

    resetn   = 1'b0;
    ex_valid = 1'b0;
    flush    = 1'b0;
    aluop    = 8'h00;
    opdata1  = 32'd0;
    opdata2  = 32'd0;
    exp_hilo = 64'd0;

    vecs[0] = '{MULT_OP,  32'hFFFFFFFD, 32'h00000005, 3,  64'hFFFFFFFF_FFFFFFF1};
    vecs[1] = '{MULTU_OP, 32'hFFFFFFFF, 32'hFFFFFFFF, 3,  64'hFFFFFFFE_00000001};
    vecs[2] = '{DIV_OP,   32'hFFFFFFF9, 32'h00000002, 33, 64'hFFFFFFFF_FFFFFFFD};
    vecs[3] = '{DIVU_OP,  32'hFFFFFFFF, 32'h00000010, 33, 64'h0000000F_0FFFFFFF};
    vecs[4] = '{DIV_OP,   32'h00001234, 32'h00000000, 1,  64'h0000000F_0FFFFFFF};
    vecs[5] = '{MTHI_OP,  32'h12345678, 32'h00000000, 0,  64'h12345678_0FFFFFFF};
    vecs[6] = '{MTLO_OP,  32'h9ABCDEF0, 32'h00000000, 0,  64'h12345678_9ABCDEF0};
    vecs[7] = '{DIV_OP,   32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000};
    vecs[8] = '{DIV_OP,   32'h00000007, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD};

    #1;
    check("reset_hilo",  hilo, 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_busy",  64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // directed table
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, st, bs);
      check($sformatf("vec%0d_stall", i), 64'(st), 64'(vecs[i].stall_n));
      check($sformatf("vec%0d_busy", i), 64'(bs), 64'((vecs[i].stall_n > 0) ? vecs[i].stall_n - 1 : 0));
      check($sformatf("vec%0d_hilo", i), hilo, vecs[i].hilo);
    end
    exp_hilo = vecs[8].hilo;

    // flush during DIV at counter 10
    ex_valid = 1'b1;
    aluop    = DIV_OP;
    opdata1  = 32'd100;
    opdata2  = 32'd3;
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("divflush_stall", 64'(stall), 64'd0);
    check("divflush_busy",  64'(busy), 64'd1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    ex_valid = 1'b0;
    check("divflush_idle", 64'(busy), 64'd0);
    check("divflush_hilo", hilo, exp_hilo);
    repeat (3) @(posedge clk);
    #1;
    check("divflush_hilo_later", hilo, exp_hilo);

    // flush in IDLE suppresses MTHI and MULT start
    ex_valid = 1'b1;
    aluop    = MTHI_OP;
    opdata1  = 32'hDEADBEEF;
    flush    = 1'b1;
    @(negedge clk);
    check("idleflush_mthi_stall", 64'(stall), 64'd0);
    aluop = MULT_OP;
    @(negedge clk);
    check("idleflush_mult_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    ex_valid = 1'b0;
    check("idleflush_busy", 64'(busy), 64'd0);
    check("idleflush_hilo", hilo, exp_hilo);

    // flush in DONE: product computed but never committed
    ex_valid = 1'b1;
    aluop    = MULT_OP;
    opdata1  = 32'd7;
    opdata2  = 32'd9;
    repeat (1 + MUL_CYCLES) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("doneflush_stall", 64'(stall), 64'd0);
    check("doneflush_busy",  64'(busy), 64'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    ex_valid = 1'b0;
    check("doneflush_hilo", hilo, exp_hilo);

    // asynchronous reset mid-MUL, then a fresh MULT
    ex_valid = 1'b1;
    aluop    = MULT_OP;
    opdata1  = 32'd5;
    opdata2  = 32'd6;
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_hilo",  hilo, 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_busy",  64'(busy), 64'd0);
    ex_valid = 1'b0;
    exp_hilo = 64'd0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    issue(MULT_OP, 32'h00010000, 32'h00010000, st, bs);
    check("postrst_stall", 64'(st), 64'(1 + MUL_CYCLES));
    check("postrst_hilo",  hilo, 64'h00000001_00000000);
    exp_hilo = 64'h00000001_00000000;

    // random operations against the model
    ops[0] = MULT_OP;
    ops[1] = MULTU_OP;
    ops[2] = DIV_OP;
    ops[3] = DIVU_OP;
    ops[4] = MTHI_OP;
    ops[5] = MTLO_OP;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 5)];
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 100);
      exp_hilo = model(op, a, b, exp_hilo);
      issue(op, a, b, st, bs);
      check($sformatf("rnd%0d_op%h_stall", i, op), 64'(st), 64'(exp_stall(op, b)));
      check($sformatf("rnd%0d_op%h_hilo", i, op), hilo, exp_hilo);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
